// File: rtl/keyfifo.sv
`timescale 1ns/1ps
// keyfifo: keypad front end for the lander console.
// The raw key levels pass through a two-flop synchroniser, a lowest-index
// priority encoder, and a debounce FSM that produces one push per press.
// The pushed codes are held in a show-ahead FIFO until the consumer pops them.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset (0 resets, 1 runs)
//   keyin      raw asynchronous key levels, 1 = pressed
//   pop        consumer acknowledge of the head entry
//   ovf_clr    synchronous clear of the sticky overflow flag
//   code       key index at the FIFO head, 0 when empty
//   valid      FIFO not empty
//   count      number of entries held, 0..DEPTH
//   overflow   sticky: a press was dropped because the FIFO was full
//   dbg_state  current debounce FSM state (IDLE=0, CHK=1, HELD=2, REL=3)
//
// Handshake: valid/code form the producer side of a show-ahead stream, and
// pop is its ready. An entry transfers on a clk edge where valid=1 and
// pop=1; pop while valid=0 has no effect. The next entry (if any) appears
// on code right after the transfer edge.
module keyfifo #(
  parameter int NKEYS    = 20,
  parameter int DEBOUNCE = 2,
  parameter int DEPTH    = 4,
  localparam int CW      = $clog2(NKEYS),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] keyin,
  input  logic             pop,
  input  logic             ovf_clr,
  output logic [CW-1:0]    code,
  output logic             valid,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int CNTW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CHK = 2'd1, HELD = 2'd2, REL = 2'd3} state_e;

  // Synchroniser
  logic [NKEYS-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= keyin;
      s2_q <= s1_q;
    end
  end

  // Priority encoder: the downward loop leaves the lowest set index last.
  logic [CW-1:0] pcode;
  logic          any;

  always_comb begin
    pcode = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (s2_q[i]) pcode = CW'(i);
    end
    any = |s2_q;
  end

  // Debounce FSM
  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]   lcode_q, lcode_d;
  logic            push;
  logic [CW-1:0]   push_code;

  assign cnt_inc = cnt_q + CNTW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lcode_d   = lcode_q;
    push      = 1'b0;
    push_code = lcode_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          lcode_d = pcode;
          cnt_d   = CNTW'(1);
          if (DEBOUNCE == 1) begin
            push      = 1'b1;
            push_code = pcode;
            state_d   = HELD;
          end else begin
            state_d = CHK;
          end
        end
      end
      CHK: begin
        if (any && (pcode == lcode_q)) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNTW'(DEBOUNCE)) begin
            push    = 1'b1;
            state_d = HELD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        // No auto-repeat; extra keys added while held are ignored.
        if (!any) begin
          cnt_d   = CNTW'(1);
          state_d = (DEBOUNCE == 1) ? IDLE : REL;
        end
      end
      REL: begin
        if (!any) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNTW'(DEBOUNCE)) state_d = IDLE;
        end else begin
          // Release bounce: go back to HELD without a new push.
          state_d = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lcode_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcode_q <= lcode_d;
    end
  end

  assign dbg_state = state_q;

  // Show-ahead FIFO
  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, pop_eff, push_ok, drop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign valid   = (count_q != '0);
  assign pop_eff = pop & valid;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop_eff);
  assign drop    = push & full & ~pop_eff;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_eff) rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_eff})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // Set wins over clear on the same edge.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= push_code;
  end

  assign code     = valid ? mem[rptr_q] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_keyfifo.sv
`timescale 1ns/1ps
module tb_keyfifo;

  localparam int NKEYS    = 20;
  localparam int DEBOUNCE = 2;
  localparam int DEPTH    = 4;
  localparam int CW       = 5;
  localparam int AW       = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NKEYS-1:0] keyin;
  logic             pop;
  logic             ovf_clr;
  logic [CW-1:0]    code;
  logic             valid;
  logic [AW:0]      count;
  logic             overflow;
  logic [1:0]       dbg_state;

  keyfifo #(
    .NKEYS   (NKEYS),
    .DEBOUNCE(DEBOUNCE),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .keyin    (keyin),
    .pop      (pop),
    .ovf_clr  (ovf_clr),
    .code     (code),
    .valid    (valid),
    .count    (count),
    .overflow (overflow),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [CW-1:0] exp_q[$];
  logic          exp_ovf;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_fifo(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(valid), 32'(exp_q.size() != 0));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) check({tag, "_code"}, 32'(code), 32'(exp_q[0]));
    else                   check({tag, "_code0"}, 32'(code), 32'd0);
  endtask

  // Drivers
  task automatic press(input int idx, input int hold);
    keyin      = '0;
    keyin[idx] = 1'b1;
    cycles(hold);
    keyin = '0;
    cycles(6);
    if (exp_q.size() < DEPTH) exp_q.push_back(CW'(idx));
    else                      exp_ovf = 1'b1;
    check_fifo($sformatf("press%0d", idx));
  endtask

  task automatic pop_one(input string tag);
    check_fifo(tag);
    pop = 1'b1;
    cycles(1);
    pop = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_fifo({tag, "_after"});
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    check_fifo("ovf_clr");
  endtask

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got=timeout expected=finish");
    report();
    $finish;
  end

  initial begin
    keyin   = '0;
    pop     = 1'b0;
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    rst     = 1'b0;
    cycles(2);
    check_fifo("reset");
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    cycles(2);

    // Glitch reject
    keyin[7] = 1'b1;
    cycles(1);
    keyin = '0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      check_fifo($sformatf("glitch%0d", i));
    end

    // Single press and latency
    keyin[13] = 1'b1;
    cycles(3);
    check("lat_edge3_valid", 32'(valid), 32'd0);
    cycles(1);
    exp_q.push_back(CW'(13));
    check_fifo("lat_edge4");
    cycles(6);
    keyin = '0;
    cycles(6);
    check_fifo("single_once");
    pop_one("single_pop");

    // Priority and ignored second key
    keyin[3] = 1'b1;
    keyin[9] = 1'b1;
    cycles(5);
    exp_q.push_back(CW'(3));
    check_fifo("prio");
    keyin[3] = 1'b0;
    cycles(8);
    check_fifo("prio_hold9");
    keyin = '0;
    cycles(6);
    pop_one("prio_pop");

    // Overflow and ordering
    for (int k = 1; k <= 5; k++) press(k, 5);
    for (int k = 0; k < 4; k++) pop_one($sformatf("order%0d", k));
    clear_ovf();

    // Full FIFO with pop on the push edge
    for (int k = 1; k <= 4; k++) press(k, 5);
    keyin[6] = 1'b1;
    cycles(3);
    check_fifo("pre_push6");
    pop = 1'b1;
    cycles(1);
    pop = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(CW'(6));
    check_fifo("push_pop_full");
    keyin = '0;
    cycles(6);
    for (int k = 0; k < 4; k++) pop_one($sformatf("drain6_%0d", k));

    // Random presses with random pops
    for (int r = 0; r < 8; r++) begin
      press(int'($urandom_range(0, NKEYS - 1)), 5);
      if ($urandom_range(0, 1) == 1 && exp_q.size() != 0) pop_one("rnd_pop");
    end
    while (exp_q.size() != 0) pop_one("rnd_drain");
    clear_ovf();

    // Release bounce
    keyin[5] = 1'b1;
    cycles(5);
    keyin = '0;
    cycles(1);
    keyin[5] = 1'b1;
    cycles(1);
    keyin = '0;
    cycles(8);
    exp_q.push_back(CW'(5));
    check_fifo("bounce");

    // Asynchronous reset with a key held and two entries queued
    keyin[8] = 1'b1;
    cycles(5);
    exp_q.push_back(CW'(8));
    check_fifo("two_queued");
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_fifo("async_rst");
    cycles(2);
    rst = 1'b1;
    cycles(3);
    check("rst_edge3_valid", 32'(valid), 32'd0);
    cycles(1);
    exp_q.push_back(CW'(8));
    check_fifo("rst_repress");
    keyin = '0;
    cycles(6);
    pop_one("final_pop");

    report();
    $finish;
  end

endmodule
